// File: rtl/ex_mdu_if.sv
// Execute-stage bus between the id/ex register, ex_mdu and the ex/mem register.
// master: id/ex side, drives operation, operands and destination.
// slave:  ex_mdu, returns destination, result and the stall request.
interface ex_mdu_if #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned AOP_W      = 4
);
    logic                  flush_i;
    logic [AOP_W-1:0]      aluop_i;
    logic [XLEN-1:0]       reg1_i;
    logic [XLEN-1:0]       reg2_i;
    logic [REG_ADDR_W-1:0] wd_i;
    logic                  wreg_i;
    logic [REG_ADDR_W-1:0] wd_o;
    logic                  wreg_o;
    logic [XLEN-1:0]       wdata_o;
    logic                  stallreq_o;

    modport master (
        output flush_i, aluop_i, reg1_i, reg2_i, wd_i, wreg_i,
        input  wd_o, wreg_o, wdata_o, stallreq_o
    );

    modport slave (
        input  flush_i, aluop_i, reg1_i, reg2_i, wd_i, wreg_i,
        output wd_o, wreg_o, wdata_o, stallreq_o
    );
endinterface

// File: rtl/ex_mdu.sv
// Execute stage: single-cycle ALU plus iterative unsigned multiply/divide.
// Ports: clk, rst (sync, active-high), bus (ex_mdu_if.slave):
//   in : flush_i, aluop_i, reg1_i, reg2_i, wd_i, wreg_i
//   out: wd_o, wreg_o, wdata_o, stallreq_o (all combinational)
module ex_mdu #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned AOP_W      = 4
) (
    input  logic      clk,
    input  logic      rst,
    ex_mdu_if.slave   bus
);
    localparam int unsigned SH_W  = $clog2(XLEN);
    localparam int unsigned CNT_W = $clog2(XLEN) + 1;

    localparam logic [AOP_W-1:0] OP_OR    = AOP_W'(1);
    localparam logic [AOP_W-1:0] OP_AND   = AOP_W'(2);
    localparam logic [AOP_W-1:0] OP_XOR   = AOP_W'(3);
    localparam logic [AOP_W-1:0] OP_ADD   = AOP_W'(4);
    localparam logic [AOP_W-1:0] OP_SUB   = AOP_W'(5);
    localparam logic [AOP_W-1:0] OP_SLL   = AOP_W'(6);
    localparam logic [AOP_W-1:0] OP_SRL   = AOP_W'(7);
    localparam logic [AOP_W-1:0] OP_SRA   = AOP_W'(8);
    localparam logic [AOP_W-1:0] OP_SLT   = AOP_W'(9);
    localparam logic [AOP_W-1:0] OP_SLTU  = AOP_W'(10);
    localparam logic [AOP_W-1:0] OP_MUL   = AOP_W'(11);
    localparam logic [AOP_W-1:0] OP_MULHU = AOP_W'(12);
    localparam logic [AOP_W-1:0] OP_DIVU  = AOP_W'(13);
    localparam logic [AOP_W-1:0] OP_REMU  = AOP_W'(14);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  acc_q, acc_d;    // product high half / partial remainder
    logic [XLEN-1:0]  lo_q, lo_d;      // multiplier->product low / dividend->quotient
    logic [XLEN-1:0]  opnd_q, opnd_d;  // multiplicand / divisor
    logic             mul_q, mul_d;
    logic             hi_q, hi_d;      // result comes from acc (MULHU, REMU)

    logic [SH_W-1:0]  shamt_c;
    logic [XLEN-1:0]  alu_c;
    logic             is_mul_c, is_div_c, start_c;
    logic [XLEN:0]    madd_c, rsh_c, rsub_c;
    logic [XLEN-1:0]  wdata_c;
    logic             stall_c;

    assign shamt_c  = bus.reg2_i[SH_W-1:0];
    assign is_mul_c = (bus.aluop_i == OP_MUL) || (bus.aluop_i == OP_MULHU);
    assign is_div_c = (bus.aluop_i == OP_DIVU) || (bus.aluop_i == OP_REMU);
    // Divide by zero resolves in a single cycle, never starts the iteration.
    assign start_c  = is_mul_c || (is_div_c && (bus.reg2_i != '0));

    // Single-cycle result; DIVU/REMU values only reach the output for a zero divisor.
    always_comb begin
        alu_c = '0;
        case (bus.aluop_i)
            OP_OR:   alu_c = bus.reg1_i | bus.reg2_i;
            OP_AND:  alu_c = bus.reg1_i & bus.reg2_i;
            OP_XOR:  alu_c = bus.reg1_i ^ bus.reg2_i;
            OP_ADD:  alu_c = bus.reg1_i + bus.reg2_i;
            OP_SUB:  alu_c = bus.reg1_i - bus.reg2_i;
            OP_SLL:  alu_c = bus.reg1_i << shamt_c;
            OP_SRL:  alu_c = bus.reg1_i >> shamt_c;
            OP_SRA:  alu_c = XLEN'($signed(bus.reg1_i) >>> shamt_c);
            OP_SLT:  alu_c = {{(XLEN-1){1'b0}}, $signed(bus.reg1_i) < $signed(bus.reg2_i)};
            OP_SLTU: alu_c = {{(XLEN-1){1'b0}}, bus.reg1_i < bus.reg2_i};
            OP_DIVU: alu_c = '1;
            OP_REMU: alu_c = bus.reg1_i;
            default: alu_c = '0;
        endcase
    end

    // One shift-add multiply step and one restoring divide step.
    always_comb begin
        madd_c = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        rsh_c  = {acc_q, lo_q[XLEN-1]};
        rsub_c = rsh_c - {1'b0, opnd_q};
    end

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        opnd_d  = opnd_q;
        mul_d   = mul_q;
        hi_d    = hi_q;
        stall_c = 1'b0;
        wdata_c = alu_c;
        case (state_q)
            S_IDLE: begin
                if (start_c) begin
                    stall_c = 1'b1;
                    wdata_c = '0;
                    state_d = S_BUSY;
                    cnt_d   = '0;
                    acc_d   = '0;
                    lo_d    = is_mul_c ? bus.reg2_i : bus.reg1_i;
                    opnd_d  = is_mul_c ? bus.reg1_i : bus.reg2_i;
                    mul_d   = is_mul_c;
                    hi_d    = (bus.aluop_i == OP_MULHU) || (bus.aluop_i == OP_REMU);
                end
            end
            S_BUSY: begin
                stall_c = 1'b1;
                wdata_c = '0;
                cnt_d   = cnt_q + CNT_W'(1);
                if (mul_q) begin
                    acc_d = madd_c[XLEN:1];
                    lo_d  = {madd_c[0], lo_q[XLEN-1:1]};
                end else if (!rsub_c[XLEN]) begin
                    acc_d = rsub_c[XLEN-1:0];
                    lo_d  = {lo_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = rsh_c[XLEN-1:0];
                    lo_d  = {lo_q[XLEN-2:0], 1'b0};
                end
                if (cnt_q == CNT_W'(XLEN-1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                wdata_c = hi_q ? acc_q : lo_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Flush squashes the current instruction and abandons any iteration.
        if (bus.flush_i) begin
            state_d = S_IDLE;
            stall_c = 1'b0;
            wdata_c = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            mul_q   <= 1'b0;
            hi_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            opnd_q  <= opnd_d;
            mul_q   <= mul_d;
            hi_q    <= hi_d;
        end
    end

    // Reset forces every output low, even mid-operation.
    assign bus.wd_o       = rst ? REG_ADDR_W'(0) : bus.wd_i;
    assign bus.wreg_o     = bus.wreg_i & ~bus.flush_i & ~rst;
    assign bus.wdata_o    = rst ? '0 : wdata_c;
    assign bus.stallreq_o = stall_c & ~rst;
endmodule

// File: tb/tb_ex_mdu.sv
module tb_ex_mdu;
    localparam int unsigned XLEN = 32;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    ex_mdu_if #(.XLEN(XLEN), .REG_ADDR_W(5), .AOP_W(4)) bus ();

    ex_mdu #(.XLEN(XLEN), .REG_ADDR_W(5), .AOP_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference results straight from the operation definitions.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd1:    return a | b;
            4'd2:    return a & b;
            4'd3:    return a ^ b;
            4'd4:    return a + b;
            4'd5:    return a - b;
            4'd6:    return a << b[4:0];
            4'd7:    return a >> b[4:0];
            4'd8:    return 32'($signed(a) >>> b[4:0]);
            4'd9:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd10:   return (a < b) ? 32'd1 : 32'd0;
            4'd13:   return 32'hFFFF_FFFF;
            4'd14:   return a;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_long(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (op)
            4'd11:   return p[31:0];
            4'd12:   return p[63:32];
            4'd13:   return a / b;
            default: return a % b;
        endcase
    endfunction

    // Cycle model: phase 0 = free, 1..XLEN = iterating, XLEN+1 = result cycle.
    int          phase = 0;
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b;
    logic [31:0] e_wdata;
    logic        e_stall, e_wreg;
    logic [4:0]  e_wd;

    always @(negedge clk) begin
        e_wd   = rst ? 5'd0 : bus.wd_i;
        e_wreg = bus.wreg_i & ~rst & ~bus.flush_i;
        if (rst || bus.flush_i) begin
            e_wdata = 32'd0;
            e_stall = 1'b0;
            phase   = 0;
        end else if (phase == 0) begin
            if ((bus.aluop_i >= 4'd11 && bus.aluop_i <= 4'd12) ||
                (bus.aluop_i >= 4'd13 && bus.aluop_i <= 4'd14 && bus.reg2_i != 32'd0)) begin
                e_wdata = 32'd0;
                e_stall = 1'b1;
                m_op    = bus.aluop_i;
                m_a     = bus.reg1_i;
                m_b     = bus.reg2_i;
                phase   = 1;
            end else begin
                e_wdata = ref_alu(bus.aluop_i, bus.reg1_i, bus.reg2_i);
                e_stall = 1'b0;
            end
        end else if (phase <= int'(XLEN)) begin
            e_wdata = 32'd0;
            e_stall = 1'b1;
            phase   = phase + 1;
        end else begin
            e_wdata = ref_long(m_op, m_a, m_b);
            e_stall = 1'b0;
            phase   = 0;
        end
        chk("cyc_wdata", bus.wdata_o, e_wdata);
        chk("cyc_stall", 32'(bus.stallreq_o), 32'(e_stall));
        chk("cyc_wreg", 32'(bus.wreg_o), 32'(e_wreg));
        chk("cyc_wd", 32'(bus.wd_o), 32'(e_wd));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.aluop_i = op;
        bus.reg1_i  = a;
        bus.reg2_i  = b;
        bus.wd_i    = 5'($urandom_range(1, 31));
        bus.wreg_i  = 1'b1;
    endtask

    // Single-cycle op: result and no stall in the same cycle.
    task automatic single(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        set_op(op, a, b);
        @(negedge clk);
        #1;
        chk(name, bus.wdata_o, exp);
        chk({name, "_stall"}, 32'(bus.stallreq_o), 32'd0);
        tick();
    endtask

    // Multi-cycle op: count stall cycles, then check the result cycle.
    task automatic run_mdu(input string name, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        int n;
        bit done;
        set_op(op, a, b);
        n    = 0;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            #1;
            if (bus.stallreq_o) begin
                n++;
                tick();
                if (i == 0) begin
                    // Inputs moving while busy must not disturb the latched operands.
                    bus.reg1_i = $urandom;
                    bus.reg2_i = $urandom;
                    bus.wd_i   = 5'($urandom_range(0, 31));
                    bus.wreg_i = 1'($urandom_range(0, 1));
                end
            end else begin
                done = 1'b1;
            end
        end
        chk({name, "_stalls"}, 32'(n), 32'd33);
        chk(name, bus.wdata_o, exp);
        tick();
    endtask

    initial begin
        rst         = 1'b1;
        bus.flush_i = 1'b0;
        bus.aluop_i = 4'd1;
        bus.reg1_i  = 32'h0F0F_0000;
        bus.reg2_i  = 32'h0000_00FF;
        bus.wd_i    = 5'd5;
        bus.wreg_i  = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_wdata", bus.wdata_o, 32'd0);
        chk("rst_wd", 32'(bus.wd_o), 32'd0);
        chk("rst_wreg", 32'(bus.wreg_o), 32'd0);
        chk("rst_stall", 32'(bus.stallreq_o), 32'd0);
        tick();
        tick();
        rst = 1'b0;

        single("or",   4'd1,  32'h0F0F_0000, 32'h0000_00FF, 32'h0F0F_00FF);
        single("and",  4'd2,  32'hF0F0_FFFF, 32'h0FF0_00F0, 32'h00F0_00F0);
        single("xor",  4'd3,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555);
        single("add",  4'd4,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001);
        single("sub",  4'd5,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF);
        single("sll",  4'd6,  32'h0000_0001, 32'h0000_003F, 32'h8000_0000);
        single("srl",  4'd7,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000);
        single("sra",  4'd8,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000);
        single("slt",  4'd9,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
        single("sltu", 4'd10, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
        single("nop",  4'd0,  32'h1234_5678, 32'h1111_1111, 32'h0000_0000);
        single("op15", 4'd15, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000);
        single("divu0", 4'd13, 32'd5, 32'd0, 32'hFFFF_FFFF);
        single("remu0", 4'd14, 32'd5, 32'd0, 32'd5);

        run_mdu("mul",   4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        run_mdu("mulhu", 4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_mdu("divu",  4'd13, 32'd100, 32'd7, 32'd14);
        run_mdu("remu",  4'd14, 32'd100, 32'd7, 32'd2);

        // Flush in cycle 10 of a divide.
        set_op(4'd13, 32'd100, 32'd7);
        for (int i = 0; i < 10; i++) tick();
        bus.flush_i = 1'b1;
        @(negedge clk);
        #1;
        chk("flush_stall", 32'(bus.stallreq_o), 32'd0);
        chk("flush_wreg", 32'(bus.wreg_o), 32'd0);
        chk("flush_wdata", bus.wdata_o, 32'd0);
        tick();
        bus.flush_i = 1'b0;
        single("post_flush_or", 4'd1, 32'h0F0F_0000, 32'h0000_00FF, 32'h0F0F_00FF);
        run_mdu("mul_after_flush", 4'd11, 32'd3, 32'd4, 32'd12);

        // Reset in cycle 20 of a divide.
        set_op(4'd13, 32'd100, 32'd7);
        for (int i = 0; i < 20; i++) tick();
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst_stall", 32'(bus.stallreq_o), 32'd0);
        chk("midrst_wreg", 32'(bus.wreg_o), 32'd0);
        chk("midrst_wd", 32'(bus.wd_o), 32'd0);
        chk("midrst_wdata", bus.wdata_o, 32'd0);
        tick();
        rst = 1'b0;
        run_mdu("mul_after_rst", 4'd11, 32'd3, 32'd4, 32'd12);

        // Back-to-back multiplies: results in cycles 33 and 67.
        run_mdu("b2b_first",  4'd11, 32'd6, 32'd7, 32'd42);
        run_mdu("b2b_second", 4'd11, 32'd6, 32'd7, 32'd42);

        set_op(4'd0, 32'd0, 32'd0);
        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
